// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: round-robin arbiter in front of one shared adder.
// A winner's operands are captured in IDLE, added in ADD, and the registered
// result is held in RESP until the consumer accepts it.
module adder_share_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned ID_W    = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ-1:0]       req_cin,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH-1:0]         rsp_sum,
    output logic                     rsp_cout,
    output logic                     rsp_overflow,
    output logic                     busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [ID_W-1:0]  r_ptr;
    logic [ID_W-1:0]  r_gnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_cin;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic [ID_W-1:0]  r_id;

    logic             w_any;
    logic [ID_W-1:0]  w_gnt;
    logic [WIDTH:0]   w_full;
    logic             w_accept;
    logic             w_rsp_done;

    // Round-robin search: first valid requester at or above r_ptr, wrapping.
    always_comb begin
        int unsigned idx;
        w_any = 1'b0;
        w_gnt = '0;
        idx   = 0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            idx = int'(r_ptr) + off;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!w_any && req_valid[idx]) begin
                w_any = 1'b1;
                w_gnt = idx[ID_W-1:0];
            end
        end
    end

    assign w_accept   = (r_state == IDLE) && w_any;
    assign w_rsp_done = (r_state == RESP) && rsp_ready;

    // One-hot ready to the winner, only while idle and out of reset.
    always_comb begin
        req_ready = '0;
        if (w_accept && rst_n) begin
            req_ready[w_gnt] = 1'b1;
        end
    end

    // Shared adder on the captured operands; bit WIDTH is the carry out.
    assign w_full = {1'b0, r_a} + {1'b0, r_b} + {{WIDTH{1'b0}}, r_cin};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (w_any) w_state_nxt = ADD;
            ADD:     w_state_nxt = RESP;
            RESP:    if (rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Operand capture on acceptance and priority pointer update on response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_cin <= 1'b0;
            r_gnt <= '0;
            r_ptr <= '0;
        end else begin
            if (w_accept) begin
                r_a   <= req_a[w_gnt*WIDTH +: WIDTH];
                r_b   <= req_b[w_gnt*WIDTH +: WIDTH];
                r_cin <= req_cin[w_gnt];
                r_gnt <= w_gnt;
            end
            if (w_rsp_done) begin
                if (r_gnt == ID_W'(NUM_REQ - 1)) begin
                    r_ptr <= '0;
                end else begin
                    r_ptr <= r_gnt + 1'b1;
                end
            end
        end
    end

    // Result registers, loaded in ADD and held through RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
            r_id   <= '0;
        end else if (r_state == ADD) begin
            r_sum  <= w_full[WIDTH-1:0];
            r_cout <= w_full[WIDTH];
            r_ovf  <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                      (w_full[WIDTH-1] != r_a[WIDTH-1]);
            r_id   <= r_gnt;
        end
    end

    assign rsp_valid    = (r_state == RESP);
    assign rsp_sum      = r_sum;
    assign rsp_cout     = r_cout;
    assign rsp_overflow = r_ovf;
    assign rsp_id       = r_id;
    assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter: inputs change and outputs are
// sampled around the falling clock edge.
module tb_adder_share_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned W    = 32;
    localparam int unsigned IDW  = 2;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_cin;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_sum;
    logic              rsp_cout;
    logic              rsp_overflow;
    logic              busy;

    logic [W-1:0] op_a [NREQ];
    logic [W-1:0] op_b [NREQ];
    logic         op_c [NREQ];

    int n_cmp;
    int n_err;

    adder_share_arbiter #(.NUM_REQ(NREQ), .WIDTH(W), .ID_W(IDW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_cin      (req_cin),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_sum      (rsp_sum),
        .rsp_cout     (rsp_cout),
        .rsp_overflow (rsp_overflow),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*W +: W] = op_a[i];
            req_b[i*W +: W] = op_b[i];
            req_cin[i]      = op_c[i];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, ".rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({tag, ".rsp_sum"},   64'(rsp_sum),   64'd0);
        chk({tag, ".rsp_cout"},  64'(rsp_cout),  64'd0);
        chk({tag, ".rsp_ovf"},   64'(rsp_overflow), 64'd0);
        chk({tag, ".rsp_id"},    64'(rsp_id),    64'd0);
        chk({tag, ".busy"},      64'(busy),      64'd0);
        chk({tag, ".req_ready"}, 64'(req_ready), 64'd0);
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        op_a[i] = a;
        op_b[i] = b;
        op_c[i] = c;
    endtask

    // Called at a falling edge with the DUT idle; completes one operation
    // with rsp_ready high and returns at the falling edge back in IDLE.
    task automatic txn(input string tag, input logic [NREQ-1:0] vmask, input int id,
                       input logic [W-1:0] es, input logic ec, input logic eo);
        logic [NREQ-1:0] onehot;
        onehot = '0;
        onehot[id] = 1'b1;
        req_valid = vmask;
        #1;
        chk({tag, ".idle_busy"}, 64'(busy), 64'd0);
        chk({tag, ".ready"},     64'(req_ready), 64'(onehot));
        @(negedge clk);
        chk({tag, ".add_busy"},  64'(busy), 64'd1);
        chk({tag, ".add_ready"}, 64'(req_ready), 64'd0);
        chk({tag, ".add_valid"}, 64'(rsp_valid), 64'd0);
        @(negedge clk);
        chk({tag, ".valid"}, 64'(rsp_valid), 64'd1);
        chk({tag, ".id"},    64'(rsp_id), 64'(id));
        chk({tag, ".sum"},   64'(rsp_sum), 64'(es));
        chk({tag, ".cout"},  64'(rsp_cout), 64'(ec));
        chk({tag, ".ovf"},   64'(rsp_overflow), 64'(eo));
        @(negedge clk);
        chk({tag, ".done_valid"}, 64'(rsp_valid), 64'd0);
        req_valid = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [W-1:0] hold_sum;
        n_cmp     = 0;
        n_err     = 0;
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) set_op(i, '0, '0, 1'b0);

        // Reset state, with a request pending during reset.
        rst_n = 1'b0;
        req_valid = 4'b0001;
        #1;
        chk_idle_zero("reset");
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single request and arithmetic corner cases on requester 0.
        set_op(0, 32'd5, 32'd7, 1'b1);
        txn("single", 4'b0001, 0, 32'd13, 1'b0, 1'b0);
        set_op(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        txn("pos_ovf", 4'b0001, 0, 32'h8000_0000, 1'b0, 1'b1);
        set_op(0, 32'h8000_0000, 32'h8000_0000, 1'b0);
        txn("neg_ovf", 4'b0001, 0, 32'h0000_0000, 1'b1, 1'b1);
        set_op(0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        txn("uwrap", 4'b0001, 0, 32'h0000_0000, 1'b1, 1'b0);

        // All four held valid from a fresh pointer: grants 0,1,2,3.
        do_reset();
        set_op(0, 32'h0000_0001, 32'h0000_0002, 1'b0);
        set_op(1, 32'h0000_0100, 32'h0000_0200, 1'b1);
        set_op(2, 32'hFFFF_FFF0, 32'h0000_0020, 1'b0);
        set_op(3, 32'h4000_0000, 32'h4000_0000, 1'b0);
        txn("rr0", 4'b1111, 0, 32'h0000_0003, 1'b0, 1'b0);
        txn("rr1", 4'b1111, 1, 32'h0000_0301, 1'b0, 1'b0);
        txn("rr2", 4'b1111, 2, 32'h0000_0010, 1'b1, 1'b0);
        txn("rr3", 4'b1111, 3, 32'h8000_0000, 1'b0, 1'b1);

        // Only requesters 1 and 3: wrap-around order 1,3,1.
        txn("sub1a", 4'b1010, 1, 32'h0000_0301, 1'b0, 1'b0);
        txn("sub3",  4'b1010, 3, 32'h8000_0000, 1'b0, 1'b1);
        txn("sub1b", 4'b1010, 1, 32'h0000_0301, 1'b0, 1'b0);

        // Backpressure: pointer is now 2; stall in RESP for 10 cycles while
        // requester 0 waits.
        rsp_ready = 1'b0;
        req_valid = 4'b0100;
        #1;
        chk("bp.ready", 64'(req_ready), 64'b0100);
        @(negedge clk);
        req_valid = 4'b0001;
        @(negedge clk);
        hold_sum = 32'h0000_0010;
        for (int c = 0; c < 10; c++) begin
            chk("bp.valid", 64'(rsp_valid), 64'd1);
            chk("bp.sum",   64'(rsp_sum), 64'(hold_sum));
            chk("bp.cout",  64'(rsp_cout), 64'd1);
            chk("bp.ovf",   64'(rsp_overflow), 64'd0);
            chk("bp.id",    64'(rsp_id), 64'd2);
            chk("bp.rdy0",  64'(req_ready), 64'd0);
            chk("bp.busy",  64'(busy), 64'd1);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        // Requester 0 was waiting: granted in the cycle right after acceptance.
        txn("bp.next", 4'b0001, 0, 32'h0000_0003, 1'b0, 1'b0);

        // Reset during ADD: pointer is 1, requester 3 wins, then aborted.
        req_valid = 4'b1000;
        #1;
        chk("rstadd.ready", 64'(req_ready), 64'b1000);
        @(negedge clk);
        req_valid = '0;
        chk("rstadd.busy", 64'(busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle_zero("rstadd.in");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rstadd.novalid", 64'(rsp_valid), 64'd0);
            chk("rstadd.nobusy",  64'(busy), 64'd0);
        end
        txn("rstadd.prio", 4'b1111, 0, 32'h0000_0003, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
